// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the 7-segment capture path.
//   * segment codes for hex 0..F, active-low, ordered {CA..CG}
//   * FSM state type and state constants (IDLE / SETTLE / HOLD)
//   * default settle length and the synchronized sample layout
package seg_pkg;

   localparam int unsigned STABLE_CYCLES_DEF = 16;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t SETTLE = 2'd1;
   localparam state_t HOLD   = 2'd2;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   // One synchronized display sample; all lines active-low.
   typedef struct packed {
      logic [3:0] an;    // {AN3..AN0}
      logic [6:0] seg;   // {CA..CG}
      logic       dpn;   // DP
   } sample_t;

endpackage

// File: rtl/seg_decode.sv
// seg_decode -- combinational 7-segment pattern to hex decoder.
//   seg   : {CA..CG}, 0 = lit
//   hex   : decoded value (0 when illegal)
//   legal : 1 when seg is one of the 16 hex glyphs
module seg_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] hex,
   output logic       legal
);

   always_comb begin
      hex   = 4'h0;
      legal = 1'b1;
      case (seg)
         SEG_0:   hex = 4'h0;
         SEG_1:   hex = 4'h1;
         SEG_2:   hex = 4'h2;
         SEG_3:   hex = 4'h3;
         SEG_4:   hex = 4'h4;
         SEG_5:   hex = 4'h5;
         SEG_6:   hex = 4'h6;
         SEG_7:   hex = 4'h7;
         SEG_8:   hex = 4'h8;
         SEG_9:   hex = 4'h9;
         SEG_A:   hex = 4'hA;
         SEG_B:   hex = 4'hB;
         SEG_C:   hex = 4'hC;
         SEG_D:   hex = 4'hD;
         SEG_E:   hex = 4'hE;
         SEG_F:   hex = 4'hF;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_capture.sv
// seg_capture -- snoops a multiplexed 4-digit 7-segment display and
// reconstructs the shown hex digits.
//   clk, reset        : clock, synchronous active-high reset
//   AN0..AN3          : active-low anode selects
//   CA..CG, DP        : active-low segment / decimal-point lines
//   digit0..digit3    : published hex value per anode position
//   dp                : published decimal points (1 = lit), bit n = position n
//   valid             : at least one full frame published
//   frame_done        : one-cycle pulse on each publication
//   err               : sticky, an undecodable pattern was captured
module seg_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       AN0,
   input  logic       AN1,
   input  logic       AN2,
   input  logic       AN3,
   input  logic       CA,
   input  logic       CB,
   input  logic       CC,
   input  logic       CD,
   input  logic       CE,
   input  logic       CF,
   input  logic       CG,
   input  logic       DP,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] dp,
   output logic       valid,
   output logic       frame_done,
   output logic       err
);

   localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

   logic [11:0]      raw, sync1, sync2;
   sample_t          smp, lat, lat_n;
   state_t           state, state_n;
   logic [15:0]      cnt, cnt_n;
   logic             sel, cap;
   logic [1:0]       pos;
   logic [3:0]       hex;
   logic             legal;
   logic [3:0][3:0]  sh_digit;
   logic [3:0]       sh_dp;
   logic [3:0]       mask, mask_n;
   logic             publish;

   assign raw = {AN3, AN2, AN1, AN0, CA, CB, CC, CD, CE, CF, CG, DP};

   // Resetting to all-ones makes the first synchronized samples look like
   // a blank, unselected display.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   assign smp = sample_t'(sync2);

   // Exactly one low anode selects a position; anything else is a gap.
   always_comb begin
      sel = 1'b1;
      pos = 2'd0;
      case (smp.an)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: sel = 1'b0;
      endcase
   end

   seg_decode u_dec (
      .seg   (smp.seg),
      .hex   (hex),
      .legal (legal)
   );

   // cnt is the length of the current run of identical selected samples;
   // capture fires on the sample that makes the run STABLE long. HOLD only
   // exists so a long run captures once.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lat_n   = lat;
      cap     = 1'b0;
      if (!sel) begin
         state_n = IDLE;
         cnt_n   = 16'd0;
      end else if (state != IDLE && smp == lat) begin
         if (state == SETTLE) begin
            cnt_n = cnt + 16'd1;
            if (cnt + 16'd1 == STABLE) begin
               cap     = 1'b1;
               state_n = HOLD;
            end
         end
      end else begin
         lat_n   = smp;
         cnt_n   = 16'd1;
         state_n = SETTLE;
         if (STABLE == 16'd1) begin
            cap     = 1'b1;
            state_n = HOLD;
         end
      end
   end

   // A full mask publishes on the following edge; a capture on that same
   // edge starts the next frame's mask.
   assign publish = (mask == 4'hF);

   always_comb begin
      mask_n = publish ? 4'h0 : mask;
      if (cap && legal)
         mask_n[pos] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 16'd0;
         lat   <= '1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         lat   <= lat_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask       <= 4'h0;
         sh_digit   <= '0;
         sh_dp      <= 4'h0;
         digit0     <= 4'h0;
         digit1     <= 4'h0;
         digit2     <= 4'h0;
         digit3     <= 4'h0;
         dp         <= 4'h0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         mask       <= mask_n;
         frame_done <= publish;
         if (publish) begin
            digit0 <= sh_digit[0];
            digit1 <= sh_digit[1];
            digit2 <= sh_digit[2];
            digit3 <= sh_digit[3];
            dp     <= sh_dp;
            valid  <= 1'b1;
         end
         if (cap) begin
            if (legal) begin
               sh_digit[pos] <= hex;
               sh_dp[pos]    <= ~smp.dpn;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_capture.sv
module tb_seg_capture;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dpn;

   logic [3:0] a_d0, a_d1, a_d2, a_d3, a_dp;
   logic       a_valid, a_fd, a_err;
   logic [3:0] b_d0, b_d1, b_d2, b_d3, b_dp;
   logic       b_valid, b_fd, b_err;

   always #5 clk = ~clk;

   seg_capture #(.STABLE_CYCLES(16)) u_dut16 (
      .clk(clk), .reset(reset),
      .AN0(an[0]), .AN1(an[1]), .AN2(an[2]), .AN3(an[3]),
      .CA(seg[6]), .CB(seg[5]), .CC(seg[4]), .CD(seg[3]),
      .CE(seg[2]), .CF(seg[1]), .CG(seg[0]), .DP(dpn),
      .digit0(a_d0), .digit1(a_d1), .digit2(a_d2), .digit3(a_d3),
      .dp(a_dp), .valid(a_valid), .frame_done(a_fd), .err(a_err)
   );

   seg_capture #(.STABLE_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .AN0(an[0]), .AN1(an[1]), .AN2(an[2]), .AN3(an[3]),
      .CA(seg[6]), .CB(seg[5]), .CC(seg[4]), .CD(seg[3]),
      .CE(seg[2]), .CF(seg[1]), .CG(seg[0]), .DP(dpn),
      .digit0(b_d0), .digit1(b_d1), .digit2(b_d2), .digit3(b_d3),
      .dp(b_dp), .valid(b_valid), .frame_done(b_fd), .err(b_err)
   );

   typedef struct {
      logic [6:0] pat;
      logic [3:0] hex;
   } dvec_t;
   dvec_t tbl [16];

   int errors = 0;
   int checks = 0;
   bit cmp_en = 0;
   int fd_a = 0;
   int fd_b = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Two-sample delay line, then "a run of N identical selected samples
   // captures once"; publication one cycle after all four are captured.
   int unsigned nm_[2] = '{16, 1};
   logic [11:0] m_s1, m_s2;
   int          run  [2];
   logic [11:0] last [2];
   logic [3:0]  shd  [2][4];
   logic [3:0]  shp  [2];
   logic [3:0]  mm   [2];
   logic [3:0]  md   [2][4];
   logic [3:0]  mdp  [2];
   logic        mv   [2];
   logic        mfd  [2];
   logic        merr [2];

   function automatic bit one_low(input logic [3:0] a);
      return $countones(~a) == 1;
   endfunction

   task automatic model_step();
      logic [11:0] cur;
      int p, hv;
      if (reset) begin
         m_s1 = '1; m_s2 = '1;
         for (int m = 0; m < 2; m++) begin
            run[m] = 0; last[m] = '1; shp[m] = 0; mm[m] = 0; mdp[m] = 0;
            mv[m] = 0; mfd[m] = 0; merr[m] = 0;
            for (int k = 0; k < 4; k++) begin shd[m][k] = 0; md[m][k] = 0; end
         end
      end else begin
         cur = m_s2; m_s2 = m_s1; m_s1 = {an, seg, dpn};
         for (int m = 0; m < 2; m++) begin
            mfd[m] = (mm[m] == 4'hF);
            if (mfd[m]) begin
               for (int k = 0; k < 4; k++) md[m][k] = shd[m][k];
               mdp[m] = shp[m];
               mv[m]  = 1'b1;
               mm[m]  = 4'h0;
            end
            if (one_low(cur[11:8])) begin
               if (run[m] > 0 && cur == last[m]) begin
                  if (run[m] <= int'(nm_[m])) run[m]++;
               end else run[m] = 1;
               last[m] = cur;
            end else run[m] = 0;
            if (run[m] == int'(nm_[m])) begin
               p = 0; hv = -1;
               for (int k = 0; k < 4; k++) if (!cur[8+k]) p = k;
               for (int c = 0; c < 16; c++) if (tbl[c].pat == cur[7:1]) hv = c;
               if (hv >= 0) begin
                  shd[m][p] = tbl[hv].hex;
                  shp[m][p] = ~cur[0];
                  mm[m][p]  = 1'b1;
               end else merr[m] = 1'b1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every cycle: both DUTs against the model; count frame_done pulses.
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         checks++;
         if ({a_d3, a_d2, a_d1, a_d0, a_dp, a_valid, a_fd, a_err} !==
             {md[0][3], md[0][2], md[0][1], md[0][0], mdp[0], mv[0], mfd[0], merr[0]}) begin
            errors++;
            $display("FAIL model16 t=%0t: got d=%h%h%h%h dp=%b v=%b fd=%b e=%b expected d=%h%h%h%h dp=%b v=%b fd=%b e=%b",
                     $time, a_d3, a_d2, a_d1, a_d0, a_dp, a_valid, a_fd, a_err,
                     md[0][3], md[0][2], md[0][1], md[0][0], mdp[0], mv[0], mfd[0], merr[0]);
         end
         checks++;
         if ({b_d3, b_d2, b_d1, b_d0, b_dp, b_valid, b_fd, b_err} !==
             {md[1][3], md[1][2], md[1][1], md[1][0], mdp[1], mv[1], mfd[1], merr[1]}) begin
            errors++;
            $display("FAIL model1 t=%0t: got d=%h%h%h%h dp=%b v=%b fd=%b e=%b expected d=%h%h%h%h dp=%b v=%b fd=%b e=%b",
                     $time, b_d3, b_d2, b_d1, b_d0, b_dp, b_valid, b_fd, b_err,
                     md[1][3], md[1][2], md[1][1], md[1][0], mdp[1], mv[1], mfd[1], merr[1]);
         end
         if (a_fd === 1'b1) fd_a++;
         if (b_fd === 1'b1) fd_b++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic show(input int p, input logic [6:0] s, input logic d_n, input int n);
      an = 4'hF; an[p] = 1'b0; seg = s; dpn = d_n;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      an = 4'hF; seg = 7'h7F; dpn = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fb0;
      tbl[0]  = '{7'b0000001, 4'h0}; tbl[1]  = '{7'b1001111, 4'h1};
      tbl[2]  = '{7'b0010010, 4'h2}; tbl[3]  = '{7'b0000110, 4'h3};
      tbl[4]  = '{7'b1001100, 4'h4}; tbl[5]  = '{7'b0100100, 4'h5};
      tbl[6]  = '{7'b0100000, 4'h6}; tbl[7]  = '{7'b0001111, 4'h7};
      tbl[8]  = '{7'b0000000, 4'h8}; tbl[9]  = '{7'b0000100, 4'h9};
      tbl[10] = '{7'b0001000, 4'hA}; tbl[11] = '{7'b1100000, 4'hB};
      tbl[12] = '{7'b0110001, 4'hC}; tbl[13] = '{7'b1000010, 4'hD};
      tbl[14] = '{7'b0110000, 4'hE}; tbl[15] = '{7'b0111000, 4'hF};

      an = 4'hF; seg = 7'h7F; dpn = 1'b1; reset = 1'b1;
      repeat (3) @(negedge clk);
      cmp_en = 1;
      chk("reset16", {a_d3, a_d2, a_d1, a_d0, a_dp, a_valid, a_fd, a_err}, 0);
      chk("reset1",  {b_d3, b_d2, b_d1, b_d0, b_dp, b_valid, b_fd, b_err}, 0);
      reset = 1'b0;

      // single digit held: captured but no frame yet
      show(3, tbl[0].pat, 1'b1, 20);
      chk("one_digit_no_frame", fd_a, 0);

      // full scan 3,2,1,0 -> one frame
      show(2, tbl[1].pat, 1'b1, 20);
      show(1, tbl[2].pat, 1'b1, 20);
      show(0, tbl[3].pat, 1'b1, 20);
      idle(5);
      chk("scan_frames16", fd_a, 1);
      chk("scan_frames1", fd_b, 1);
      chk("scan_digits", {a_d3, a_d2, a_d1, a_d0}, 32'h0123);
      chk("scan_valid", a_valid, 1);
      chk("scan_err", a_err, 0);

      // two anodes low: nothing captured, outputs unchanged
      an = 4'b1100; seg = tbl[8].pat; dpn = 1'b0;
      repeat (50) @(negedge clk);
      chk("multi_an_frames", fd_a, 1);
      chk("multi_an_out", {a_d3, a_d2, a_d1, a_d0, a_dp, a_valid}, {16'h0123, 4'h0, 1'b1});

      // illegal pattern on AN2: err sticky, position 2 not marked
      show(2, 7'h7F, 1'b1, 20);
      chk("illegal_err16", a_err, 1);
      chk("illegal_err1", b_err, 1);
      show(0, tbl[4].pat, 1'b1, 20);
      show(1, tbl[5].pat, 1'b1, 20);
      show(3, tbl[6].pat, 1'b1, 20);
      idle(5);
      chk("illegal_mask_kept", fd_a, 1);
      show(2, tbl[7].pat, 1'b1, 20);
      idle(5);
      chk("illegal_then_frame", fd_a, 2);
      chk("illegal_digits", {a_d3, a_d2, a_d1, a_d0}, 32'h6754);
      chk("err_sticky", a_err, 1);

      // pattern toggling faster than the settle time never captures
      for (int i = 0; i < 6; i++) show(1, (i % 2) ? tbl[9].pat : tbl[8].pat, 1'b1, 10);
      show(0, tbl[10].pat, 1'b1, 20);
      show(2, tbl[11].pat, 1'b1, 20);
      show(3, tbl[12].pat, 1'b1, 20);
      chk("toggle_no_capture", fd_a, 2);

      // reset mid-settle discards the partial frame
      show(1, tbl[13].pat, 1'b1, 8);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("midreset16", {a_d3, a_d2, a_d1, a_d0, a_dp, a_valid, a_fd, a_err}, 0);
      chk("midreset1",  {b_d3, b_d2, b_d1, b_d0, b_dp, b_valid, b_fd, b_err}, 0);
      reset = 1'b0;
      show(1, tbl[13].pat, 1'b1, 20);
      idle(5);
      chk("partial_discarded", fd_a, 2);

      // STABLE_CYCLES = 1, fast scan, DP lit on AN1
      fb0 = fd_b;
      show(3, tbl[1].pat, 1'b1, 3);
      show(2, tbl[2].pat, 1'b1, 3);
      show(1, tbl[3].pat, 1'b0, 3);
      show(0, tbl[4].pat, 1'b1, 3);
      idle(5);
      chk("fast_frames1", fd_b, fb0 + 1);
      chk("fast_dp1", b_dp, 4'b0010);
      chk("fast_digits1", {b_d3, b_d2, b_d1, b_d0}, 32'h1234);
      chk("fast_no_frame16", fd_a, 2);

      // every glyph through the decoder, four per frame
      for (int f = 0; f < 4; f++) begin
         for (int p = 0; p < 4; p++) show(p, tbl[4*f+p].pat, p[0], 20);
         idle(4);
         chk("decode_digits", {a_d3, a_d2, a_d1, a_d0},
             {16'h0, tbl[4*f+3].hex, tbl[4*f+2].hex, tbl[4*f+1].hex, tbl[4*f].hex});
         chk("decode_dp", a_dp, 4'b0101);
      end

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
         end
         if ($urandom_range(0, 9) < 8) begin
            an = 4'hF; an[$urandom_range(0, 3)] = 1'b0;
         end else an = 4'($urandom);
         seg = ($urandom_range(0, 19) < 17) ? tbl[$urandom_range(0, 15)].pat : 7'($urandom);
         dpn = 1'($urandom);
         repeat ($urandom_range(1, 24)) @(negedge clk);
      end
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
